// File: rtl/fp_divider.sv
// -----------------------------------------------------------------------------
// fp_divider
//   Multi-cycle IEEE 754 single-precision divider, q = a / b.
//   The mantissa quotient comes from a restoring shift-subtract loop that
//   produces one bit per cycle. Denormal operands are flushed to zero, and the
//   result is truncated (the remainder is dropped).
//
// Ports
//   clk    in   1   clock; all state changes on its rising edge
//   rst    in   1   asynchronous, active-high reset
//   start  in   1   request pulse; sampled only while idle
//   a      in  32   dividend (IEEE 754 single)
//   b      in  32   divisor  (IEEE 754 single)
//   busy   out  1   high in every state except IDLE
//   done   out  1   one-cycle pulse when q is valid
//   q      out 32   quotient; held until a new result is written
//   flags  out  3   {dz, ovf, unf}; present only when FPD_FLAGS_EN is defined
//
// Configuration macro: FPD_FLAGS_EN adds the flags port and its logic.
//
// Latency: normal results assert done after edge 28, and special cases after
// edge 2. Edge 1 is the edge that samples start.
// -----------------------------------------------------------------------------
module fp_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] q
`ifdef FPD_FLAGS_EN
    ,
    output logic [2:0]  flags
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        DIVIDE = 3'd2,
        NORM   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [24:0] rem_r;     // partial remainder; always < 2*divisor, so 25 bits suffice
    logic [24:0] qt_r;      // quotient bits, MSB first
    logic [4:0]  iter_r;

    // Operand classification and special-case result
    logic        sign_s;
    logic        a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic        nan_case_s;
    logic        special_s;
    logic [31:0] special_q_s;

    // Classify the latched operands and pick the special-case result by priority.
    always_comb begin
        sign_s      = a_r[31] ^ b_r[31];
        a_zero_s    = (a_r[30:23] == 8'd0);
        b_zero_s    = (b_r[30:23] == 8'd0);
        a_inf_s     = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
        b_inf_s     = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
        a_nan_s     = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
        b_nan_s     = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);
        nan_case_s  = a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s);
        special_s   = nan_case_s || b_zero_s || a_inf_s || a_zero_s || b_inf_s;
        if (nan_case_s) begin
            special_q_s = 32'h7FC0_0000;
        end else if (b_zero_s || a_inf_s) begin
            special_q_s = {sign_s, 8'hFF, 23'd0};
        end else begin
            special_q_s = {sign_s, 31'd0};
        end
    end

    // One restoring step: subtract the divisor when it fits, then shift left.
    logic [24:0] div_s;
    logic        fits_s;
    logic [24:0] next_rem_s;

    // Compute the next partial remainder and quotient bit.
    always_comb begin
        div_s  = {2'b01, b_r[22:0]};
        fits_s = (rem_r >= div_s);
        if (fits_s) begin
            next_rem_s = rem_r - div_s;
        end else begin
            next_rem_s = rem_r;
        end
    end

    // Normalisation of the quotient into the final result
    logic [9:0]  exp_s;     // two's complement, 10 bits
    logic [22:0] man_s;
    logic        ovf_s;
    logic        unf_s;
    logic [31:0] norm_q_s;

    // Normalise the quotient, bias the exponent, and saturate to inf or zero.
    always_comb begin
        exp_s = {2'b00, a_r[30:23]} - {2'b00, b_r[30:23]} + (qt_r[24] ? 10'd127 : 10'd126);
        if (qt_r[24]) begin
            man_s = qt_r[23:1];
        end else begin
            man_s = qt_r[22:0];
        end
        ovf_s = !exp_s[9] && (exp_s >= 10'd255);
        unf_s = exp_s[9] || (exp_s == 10'd0);
        if (ovf_s) begin
            norm_q_s = {sign_s, 8'hFF, 23'd0};
        end else if (unf_s) begin
            norm_q_s = {sign_s, 31'd0};
        end else begin
            norm_q_s = {sign_s, exp_s[7:0], man_s};
        end
    end

    // Control FSM with registered busy/done/q/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            q       <= 32'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            rem_r   <= 25'd0;
            qt_r    <= 25'd0;
            iter_r  <= 5'd0;
`ifdef FPD_FLAGS_EN
            flags   <= 3'b000;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        busy    <= 1'b1;
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    if (special_s) begin
                        q       <= special_q_s;
                        done    <= 1'b1;
`ifdef FPD_FLAGS_EN
                        flags   <= {(!nan_case_s && b_zero_s), 2'b00};
`endif
                        state_r <= DONE;
                    end else begin
                        rem_r   <= {1'b0, 1'b1, a_r[22:0]};
                        qt_r    <= 25'd0;
                        iter_r  <= 5'd0;
                        state_r <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_r  <= next_rem_s << 1;
                    qt_r   <= {qt_r[23:0], fits_s};
                    iter_r <= iter_r + 5'd1;
                    if (iter_r == 5'd24) begin
                        state_r <= NORM;
                    end
                end
                NORM: begin
                    q       <= norm_q_s;
                    done    <= 1'b1;
`ifdef FPD_FLAGS_EN
                    flags   <= {1'b0, ovf_s, unf_s};
`endif
                    state_r <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// -----------------------------------------------------------------------------
// tb_fp_divider
//   Directed-vector bench for fp_divider with hand-computed expected quotients,
//   latencies and (when FPD_FLAGS_EN is defined) flags.
// -----------------------------------------------------------------------------
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] q;
`ifdef FPD_FLAGS_EN
    logic [2:0]  flags;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q)
`ifdef FPD_FLAGS_EN
        ,
        .flags (flags)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands and pulse start so that it is sampled on the next edge (edge 1).
    task automatic launch(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Run one operation. Check busy, latency in edges, q, flags, and the return to idle.
    task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eq, input int elat, input logic [2:0] eflags);
        int n;
        launch(va, vb);
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".latency"}, n, elat);
        check({tag, ".q"}, q, eq);
`ifdef FPD_FLAGS_EN
        check({tag, ".flags"}, {29'd0, flags}, {29'd0, eflags});
`else
        if (eflags != 3'b000) begin
            n = n;
        end
`endif
        @(posedge clk);
        #1;
        check({tag, ".done_low"}, {31'd0, done}, 32'd0);
        check({tag, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dones;
        int first_edge;
        int edge_n;
        logic [31:0] q_seen;

        rst   = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.q", q, 32'd0);
`ifdef FPD_FLAGS_EN
        check("reset.flags", {29'd0, flags}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Normal path
        run_op("div_8_2",    32'h4100_0000, 32'h4000_0000, 32'h4080_0000, 28, 3'b000);
        run_op("div_1_3",    32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 28, 3'b000);
        run_op("div_m10_5",  32'hC120_0000, 32'h40A0_0000, 32'hC000_0000, 28, 3'b000);
        run_op("div_1p5_1p25", 32'h3FC0_0000, 32'h3FA0_0000, 32'h3F99_9999, 28, 3'b000);
        run_op("underflow",  32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 28, 3'b001);

        // Special cases
        run_op("div_by_zero", 32'h40A0_0000, 32'h0000_0000, 32'h7F80_0000, 2, 3'b100);
        run_op("neg_by_zero", 32'hC0A0_0000, 32'h0000_0000, 32'hFF80_0000, 2, 3'b100);
        run_op("zero_zero",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 2, 3'b000);
        run_op("inf_inf",     32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 2, 3'b000);
        run_op("nan_b",       32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 2, 3'b000);
        run_op("inf_by_2",    32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 2, 3'b000);
        run_op("zero_by_5",   32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 2, 3'b000);
        run_op("five_by_inf", 32'h40A0_0000, 32'hFF80_0000, 32'h8000_0000, 2, 3'b000);
        run_op("denorm_a",    32'h0040_0000, 32'h4000_0000, 32'h0000_0000, 2, 3'b000);

        // Overflow while a second start arrives mid-DIVIDE and must be ignored
        launch(32'h7F00_0000, 32'h3E80_0000);
        repeat (9) @(posedge clk);
        @(negedge clk);
        a     = 32'h4100_0000;
        b     = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        edge_n     = 11;
        dones      = 0;
        first_edge = 0;
        q_seen     = 32'd0;
        repeat (50) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (done === 1'b1) begin
                dones++;
                if (first_edge == 0) begin
                    first_edge = edge_n;
                    q_seen     = q;
                end
            end
        end
        check("ovf.done_count", dones, 1);
        check("ovf.latency", first_edge, 28);
        check("ovf.q", q_seen, 32'h7F80_0000);
`ifdef FPD_FLAGS_EN
        check("ovf.flags", {29'd0, flags}, {29'd0, 3'b010});
`endif

        // Reset in the middle of DIVIDE, during iteration 10 (edge 12)
        launch(32'h4100_0000, 32'h4000_0000);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.q", q, 32'd0);
        check("abort.done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                dones++;
            end
        end
        check("abort.no_done", dones, 0);
        run_op("after_abort", 32'h4100_0000, 32'h4000_0000, 32'h4080_0000, 28, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
